frame_update_scheduler: RTL and testbench
=========================================

Name: frame_update_scheduler

Overview:
- Sequences per-frame game-state updates (physics, collision, score) into the vertical-blanking window of the 640x480 VGA timing generator.
- Watches the pixel tick and the x/y scan counters. At the start of vblank it grants each enabled update client a start/done handshake in fixed index order.
- Emits a one-cycle commit pulse when all clients finish, so the renderer latches a coherent state. If the window expires before completion, the frame is aborted and an overrun is flagged.

Parameters:
- N_CLIENTS, 3, number of update clients (1..8).
- VD, 480, first non-display line; vblank begins here.
- CLIENT_TIMEOUT, 4096, max clk cycles a client may spend in WAIT before it is faulted.
- FCNT_W, 16, width of the committed-frame counter.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high.
- pix_tick  in  1  one-clk pixel-enable strobe from the timing generator.
- x  in  10  horizontal scan count.
- y  in  10  vertical scan count.
- enable_mask  in  N_CLIENTS  per-client enable; sampled in SELECT.
- done  in  N_CLIENTS  client completion, level or pulse; only the active client's bit is honoured.
- clear_faults  in  1  synchronous clear of fault, overrun and overrun_count.
- start  out  N_CLIENTS  one-hot, one-cycle start pulse to the active client.
- commit  out  1  one-cycle pulse: all clients finished this frame.
- abort  out  1  one-cycle pulse: frame abandoned at the deadline.
- busy  out  1  high in any state other than IDLE.
- fault  out  N_CLIENTS  sticky per-client timeout flags.
- overrun  out  1  sticky: at least one frame was aborted.
- overrun_count  out  8  saturating count of aborted frames.
- frame_count  out  FCNT_W  committed-frame count; wraps to 0.

Behaviour:
- Events, all qualified by pix_tick:
  - vblank_start = pix_tick & x==0 & y==VD.
  - deadline = pix_tick & x==0 & y==0.
- Reset: all outputs and counters are 0; FSM=IDLE; client index=0; wait counter=0.
- FSM states: IDLE, SELECT, ISSUE, WAIT, COMMIT, ABORT. Outputs are decoded from the state register, so they are glitch-free.
- IDLE: vblank_start -> SELECT with index=0. deadline is ignored in IDLE.
- SELECT (1 cycle per index examined):
  - enable_mask[i]=1 -> ISSUE.
  - Otherwise, if i==N-1 -> COMMIT; else i+1 and stay in SELECT.
- ISSUE: start[i]=1 for exactly this cycle; clear the wait counter -> WAIT.
- WAIT:
  - done[i] -> COMMIT if i==N-1, else SELECT(i+1).
  - Wait counter reaches CLIENT_TIMEOUT-1 without done -> set fault[i], then advance exactly as if done.
  - Bits done[j] with j!=i are ignored.
- COMMIT: commit=1 for this cycle; frame_count+1 (wraps) -> IDLE.
- Deadline in SELECT, ISSUE or WAIT:
  - Go to ABORT, which asserts abort=1 for one cycle, sets overrun and increments overrun_count (saturates at 255) -> IDLE.
  - No commit is issued and frame_count is unchanged.
  - The deadline wins over a done arriving in the same cycle.
- COMMIT and ABORT are not interruptible.
- vblank_start outside IDLE is ignored; only one schedule runs per frame.
- clear_faults in the same cycle as a fault-set or overrun-set event: the set wins.
- Nominal latency: vblank_start sampled at cycle T -> SELECT(0) at T+1 -> start[0] at T+2.
- Asynchronous reset mid-frame returns to IDLE at once; no start, commit or abort pulse is generated.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SELECT, ISSUE, WAIT, COMMIT, ABORT);
  - VGA timing constants VD=480, HMAX=799, VMAX=524, shared with the VGA timing generator;
  - the client index width, clog2(N_CLIENTS).
- One sub-module: vblank_event_detect, which produces the registered-free vblank_start and deadline strobes from pix_tick, x and y. The FSM, counters and flags stay in the top module.

Test Plan:
- Normal frame: N=3, mask=3'b111, vblank_start at T; done[0] at T+8, done[1] at T+15, done[2] at T+30 -> start pulses at T+2, T+10, T+17; commit at T+31; frame_count 0->1; abort never asserted.
- Skip: mask=3'b101 -> start[0] then start[2], start[1] never pulses. mask=3'b000 -> SELECT at T+1, T+2, T+3; commit at T+4; no start pulses.
- Timeout: CLIENT_TIMEOUT=16, client 1 never asserts done -> fault=3'b010 after 16 WAIT cycles; start[2] follows; commit still issued. clear_faults then returns fault to 0.
- Deadline: done[2] withheld until after the y==0, x==0 tick -> abort pulses once; overrun=1; overrun_count=1; no commit; frame_count unchanged. Next vblank schedules normally from index 0.
- Collisions: deadline coincident with done[2] -> abort, not commit. Stray done[2] while client 0 is active -> ignored. vblank_start while busy -> ignored.
- Reset: assert reset while in WAIT for client 1 -> all outputs 0 immediately; after release the next vblank_start gives start[0] at T+2. 256 aborts -> overrun_count saturates at 255.

Source files
------------

// File: rtl/frame_update_scheduler_pkg.sv
// Shared definitions for the frame update scheduler.
// The VGA timing constants are also used by the VGA timing generator.
package frame_update_scheduler_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_COMMIT = 3'd4,
    S_ABORT  = 3'd5
  } fus_state_t;

  // 640x480 VGA timing: first non-display line, last pixel, last line
  localparam int VD   = 480;
  localparam int HMAX = 799;
  localparam int VMAX = 524;

  // Width of an index that can address n items (never narrower than 1 bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vblank_event_detect.sv
// Decodes the vblank-start and frame-deadline strobes from the pixel tick
// and the scan counters. Purely combinational; the strobes are one clk wide
// because pix_tick is.
module vblank_event_detect #(
  parameter int VD = frame_update_scheduler_pkg::VD
) (
  input  logic       pix_tick,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       vblank_start,
  output logic       deadline
);
  import frame_update_scheduler_pkg::*;

  localparam logic [9:0] VD_LINE = 10'(VD);

  logic line_start;

  assign line_start   = pix_tick && (x == 10'd0);
  assign vblank_start = line_start && (y == VD_LINE);
  assign deadline     = line_start && (y == 10'd0);

endmodule

// File: rtl/frame_update_scheduler.sv
// Frame update scheduler: at the start of vblank, hands each enabled update
// client a start/done handshake in index order, then pulses commit. If the
// top of the next frame arrives first, the frame is aborted and an overrun
// is recorded.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for vblank start; deadline ignored
// SELECT | examining client idx; skips disabled clients one per cycle
// ISSUE  | start[idx] pulses; wait timer loaded
// WAIT   | waiting for done[idx] or the wait timer to expire
// COMMIT | commit pulse; frame counter advances
// ABORT  | abort pulse; overrun flag and count updated
module frame_update_scheduler #(
  parameter int N_CLIENTS      = 3,
  parameter int VD             = frame_update_scheduler_pkg::VD,
  parameter int CLIENT_TIMEOUT = 4096,
  parameter int FCNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_tick,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic [N_CLIENTS-1:0] enable_mask,
  input  logic [N_CLIENTS-1:0] done,
  input  logic                 clear_faults,
  output logic [N_CLIENTS-1:0] start,
  output logic                 commit,
  output logic                 abort,
  output logic                 busy,
  output logic [N_CLIENTS-1:0] fault,
  output logic                 overrun,
  output logic [7:0]           overrun_count,
  output logic [FCNT_W-1:0]    frame_count
);
  import frame_update_scheduler_pkg::*;

  localparam int IDX_W  = idx_width(N_CLIENTS);
  localparam int WCNT_W = idx_width(CLIENT_TIMEOUT);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CLIENTS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(CLIENT_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

  fus_state_t        state;
  fus_state_t        state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [WCNT_W-1:0] wait_cnt;

  logic vblank_start;
  logic deadline;
  logic last_client;
  logic active_done;
  logic timeout_hit;
  logic fault_set;

  vblank_event_detect #(
    .VD (VD)
  ) u_vblank_event_detect (
    .pix_tick     (pix_tick),
    .x            (x),
    .y            (y),
    .vblank_start (vblank_start),
    .deadline     (deadline)
  );

  assign last_client = (idx == LAST_IDX);
  assign active_done = done[idx];
  // Down-counter loaded with TIMEOUT-1 in ISSUE; terminal count is zero,
  // reached on the CLIENT_TIMEOUT-th WAIT cycle.
  assign timeout_hit = (wait_cnt == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, client index and decoded outputs
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    fault_set = 1'b0;
    start     = '0;
    commit    = 1'b0;
    abort     = 1'b0;
    busy      = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (vblank_start) begin
          state_nxt = S_SELECT;
          idx_nxt   = '0;
        end
      end

      S_SELECT: begin
        if (deadline) begin
          state_nxt = S_ABORT;
        end else if (enable_mask[idx]) begin
          state_nxt = S_ISSUE;
        end else if (last_client) begin
          state_nxt = S_COMMIT;
        end else begin
          idx_nxt = idx + IDX_ONE;
        end
      end

      S_ISSUE: begin
        start[idx] = 1'b1;
        state_nxt  = deadline ? S_ABORT : S_WAIT;
      end

      S_WAIT: begin
        if (deadline) begin
          state_nxt = S_ABORT;
        end else if (active_done || timeout_hit) begin
          // A done on the terminal-count cycle still counts as completion.
          fault_set = !active_done;
          if (last_client) begin
            state_nxt = S_COMMIT;
          end else begin
            state_nxt = S_SELECT;
            idx_nxt   = idx + IDX_ONE;
          end
        end
      end

      S_COMMIT: begin
        commit    = 1'b1;
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end

      S_ABORT: begin
        abort     = 1'b1;
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end

      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Active client index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else begin
      idx <= idx_nxt;
    end
  end

  // Per-client wait timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == S_WAIT) && !timeout_hit) begin
      wait_cnt <= wait_cnt - WCNT_ONE;
    end
  end

  // Sticky timeout flags; a set in the same cycle as clear_faults wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault <= '0;
    end else begin
      if (clear_faults) begin
        fault <= '0;
      end
      if (fault_set) begin
        fault[idx] <= 1'b1;
      end
    end
  end

  // Overrun flag and saturating abort count; an abort beats clear_faults
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun       <= 1'b0;
      overrun_count <= 8'd0;
    end else if (state == S_ABORT) begin
      overrun <= 1'b1;
      if (clear_faults) begin
        overrun_count <= 8'd1;
      end else if (overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end else if (clear_faults) begin
      overrun       <= 1'b0;
      overrun_count <= 8'd0;
    end
  end

  // Committed-frame counter, wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (state == S_COMMIT) begin
      frame_count <= frame_count + FCNT_ONE;
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler (3 clients, 16-cycle timeout).
// Cycle c of a frame is the clock period c edges after the vblank_start
// cycle; inputs are driven and outputs sampled 1 time unit after each edge.
module tb_frame_update_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [2:0]  enable_mask;
  logic [2:0]  done;
  logic        clear_faults;
  logic [2:0]  start;
  logic        commit;
  logic        abort;
  logic        busy;
  logic [2:0]  fault;
  logic        overrun;
  logic [7:0]  overrun_count;
  logic [15:0] frame_count;

  int total  = 0;
  int passed = 0;

  frame_update_scheduler #(
    .N_CLIENTS      (3),
    .VD             (480),
    .CLIENT_TIMEOUT (16),
    .FCNT_W         (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pix_tick      (pix_tick),
    .x             (x),
    .y             (y),
    .enable_mask   (enable_mask),
    .done          (done),
    .clear_faults  (clear_faults),
    .start         (start),
    .commit        (commit),
    .abort         (abort),
    .busy          (busy),
    .fault         (fault),
    .overrun       (overrun),
    .overrun_count (overrun_count),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pix_tick     = 1'b0;
    x            = 10'd1;
    y            = 10'd1;
    done         = 3'b000;
    clear_faults = 1'b0;
  endtask

  task automatic drive_vblank();
    pix_tick = 1'b1;
    x        = 10'd0;
    y        = 10'd480;
  endtask

  task automatic drive_deadline();
    pix_tick = 1'b1;
    x        = 10'd0;
    y        = 10'd0;
  endtask

  // vblank, deadline in the following SELECT cycle, then back to IDLE
  task automatic do_abort();
    drive_vblank();
    tick();
    drive_deadline();
    tick();
    set_idle();
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    enable_mask = 3'b000;
    set_idle();
    tick();
    tick();

    chk("reset start", start, 0);
    chk("reset commit", commit, 0);
    chk("reset abort", abort, 0);
    chk("reset busy", busy, 0);
    chk("reset fault", fault, 0);
    chk("reset overrun", overrun, 0);
    chk("reset overrun_count", overrun_count, 0);
    chk("reset frame_count", frame_count, 0);
    reset = 1'b0;
    tick();

    // Normal frame, plus a stray done[2] during client 0 and a vblank while busy
    enable_mask = 3'b111;
    drive_vblank();
    for (int c = 1; c <= 32; c++) begin
      tick();
      pix_tick = (c == 12);
      x        = (c == 12) ? 10'd0 : 10'd1;
      y        = 10'd480;
      done     = (c == 5)  ? 3'b100 :
                 (c == 8)  ? 3'b001 :
                 (c == 15) ? 3'b010 :
                 (c == 30) ? 3'b100 : 3'b000;
      chk($sformatf("normal start c%0d", c), start,
          (c == 2) ? 1 : (c == 10) ? 2 : (c == 17) ? 4 : 0);
      chk($sformatf("normal commit c%0d", c), commit, (c == 31) ? 1 : 0);
      chk($sformatf("normal abort c%0d", c), abort, 0);
      chk($sformatf("normal busy c%0d", c), busy, (c <= 31) ? 1 : 0);
    end
    chk("normal frame_count", frame_count, 1);
    set_idle();
    tick();

    // Skip disabled client 1
    enable_mask = 3'b101;
    drive_vblank();
    for (int c = 1; c <= 9; c++) begin
      tick();
      set_idle();
      done = (c == 3) ? 3'b001 : (c == 7) ? 3'b100 : 3'b000;
      chk($sformatf("skip start c%0d", c), start, (c == 2) ? 1 : (c == 6) ? 4 : 0);
      chk($sformatf("skip commit c%0d", c), commit, (c == 8) ? 1 : 0);
      chk($sformatf("skip busy c%0d", c), busy, (c <= 8) ? 1 : 0);
    end
    chk("skip frame_count", frame_count, 2);
    set_idle();
    tick();

    // No clients enabled: three SELECT cycles then commit
    enable_mask = 3'b000;
    drive_vblank();
    for (int c = 1; c <= 5; c++) begin
      tick();
      set_idle();
      chk($sformatf("empty start c%0d", c), start, 0);
      chk($sformatf("empty commit c%0d", c), commit, (c == 4) ? 1 : 0);
      chk($sformatf("empty busy c%0d", c), busy, (c <= 4) ? 1 : 0);
    end
    chk("empty frame_count", frame_count, 3);

    // Client 1 times out after 16 WAIT cycles; schedule continues
    enable_mask = 3'b111;
    drive_vblank();
    for (int c = 1; c <= 26; c++) begin
      tick();
      set_idle();
      done = (c == 3) ? 3'b001 : (c == 24) ? 3'b100 : 3'b000;
      chk($sformatf("timeout start c%0d", c), start,
          (c == 2) ? 1 : (c == 5) ? 2 : (c == 23) ? 4 : 0);
      chk($sformatf("timeout fault c%0d", c), fault, (c >= 22) ? 2 : 0);
      chk($sformatf("timeout commit c%0d", c), commit, (c == 25) ? 1 : 0);
    end
    chk("timeout frame_count", frame_count, 4);
    clear_faults = 1'b1;
    tick();
    clear_faults = 1'b0;
    chk("clear_faults fault", fault, 0);

    // Deadline while client 2 still working; done[2] arrives too late
    drive_vblank();
    for (int c = 1; c <= 15; c++) begin
      tick();
      set_idle();
      if (c == 12) drive_deadline();
      done = (c == 3) ? 3'b001 : (c == 6) ? 3'b010 : (c == 14) ? 3'b100 : 3'b000;
      chk($sformatf("deadline start c%0d", c), start,
          (c == 2) ? 1 : (c == 5) ? 2 : (c == 8) ? 4 : 0);
      chk($sformatf("deadline abort c%0d", c), abort, (c == 13) ? 1 : 0);
      chk($sformatf("deadline commit c%0d", c), commit, 0);
      chk($sformatf("deadline busy c%0d", c), busy, (c <= 13) ? 1 : 0);
      chk($sformatf("deadline overrun c%0d", c), overrun, (c >= 14) ? 1 : 0);
      chk($sformatf("deadline ovr_count c%0d", c), overrun_count, (c >= 14) ? 1 : 0);
    end
    chk("deadline frame_count", frame_count, 4);

    // Next frame restarts at client 0; deadline coincides with done[2]
    drive_vblank();
    for (int c = 1; c <= 12; c++) begin
      tick();
      set_idle();
      if (c == 10) drive_deadline();
      done = (c == 3) ? 3'b001 : (c == 6) ? 3'b010 : (c == 10) ? 3'b100 : 3'b000;
      chk($sformatf("collide start c%0d", c), start,
          (c == 2) ? 1 : (c == 5) ? 2 : (c == 8) ? 4 : 0);
      chk($sformatf("collide abort c%0d", c), abort, (c == 11) ? 1 : 0);
      chk($sformatf("collide commit c%0d", c), commit, 0);
    end
    chk("collide overrun_count", overrun_count, 2);
    chk("collide frame_count", frame_count, 4);

    // Reset while waiting on client 1
    drive_vblank();
    for (int c = 1; c <= 7; c++) begin
      tick();
      set_idle();
      done = (c == 3) ? 3'b001 : 3'b000;
      chk($sformatf("prereset start c%0d", c), start, (c == 2) ? 1 : (c == 5) ? 2 : 0);
    end
    reset = 1'b1;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset start", start, 0);
    chk("midreset commit", commit, 0);
    chk("midreset abort", abort, 0);
    chk("midreset overrun", overrun, 0);
    chk("midreset overrun_count", overrun_count, 0);
    chk("midreset frame_count", frame_count, 0);
    tick();
    reset = 1'b0;
    tick();
    drive_vblank();
    for (int c = 1; c <= 3; c++) begin
      tick();
      set_idle();
      chk($sformatf("postreset start c%0d", c), start, (c == 2) ? 1 : 0);
    end

    // Abort the pending frame, then saturate the overrun counter
    drive_deadline();
    tick();
    set_idle();
    chk("sat first abort", abort, 1);
    tick();
    chk("sat first count", overrun_count, 1);
    for (int i = 0; i < 254; i++) begin
      do_abort();
    end
    chk("sat count at 255", overrun_count, 255);
    do_abort();
    chk("sat count held", overrun_count, 255);
    chk("sat overrun", overrun, 1);
    chk("sat frame_count", frame_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
